// File: rtl/seg_pkg.sv
// ----------------------------------------------------------------------------
// seg_pkg
// Shared definitions for the timer_60s display readback path.
//   - Active-low seven-segment codes (bit6 = a ... bit0 = g) for digits 0..9
//     and the blank pattern.
//   - Decoded-digit markers for blank and undecodable codes.
//   - Bit positions inside the 3-bit error vector {tens>9, ge bad, xiao bad}.
//   - The sampled display bundle, the receiver FSM state type and a small
//     helper that turns a decoded digit into an ASCII character.
// ----------------------------------------------------------------------------
package seg_pkg;

    localparam logic [6:0] SEG_0     = 7'b0000001;
    localparam logic [6:0] SEG_1     = 7'b1001111;
    localparam logic [6:0] SEG_2     = 7'b0010010;
    localparam logic [6:0] SEG_3     = 7'b0000110;
    localparam logic [6:0] SEG_4     = 7'b1001100;
    localparam logic [6:0] SEG_5     = 7'b0100100;
    localparam logic [6:0] SEG_6     = 7'b0100000;
    localparam logic [6:0] SEG_7     = 7'b0001111;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0000100;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] BCD_BLANK = 4'hE;
    localparam logic [3:0] BCD_BAD   = 4'hF;

    localparam int ERR_TENS = 2;
    localparam int ERR_GE   = 1;
    localparam int ERR_XIAO = 0;

    // One complete display sample. Ordering matches {tens, ge, xiao, point, led}.
    typedef struct packed {
        logic [3:0] tens;
        logic [6:0] ge;
        logic [6:0] xiao;
        logic       point;
        logic       led;
    } disp_t;

    typedef enum logic {
        ST_TRACK = 1'b0,   // watching for the next qualified value
        ST_HOLD  = 1'b1    // record presented, waiting for the consumer
    } rx_state_e;

    // Decoded digit -> ASCII: 0..9 -> "0".."9", blank -> " ", anything else -> "?".
    function automatic logic [7:0] digit_to_ascii(input logic [3:0] d);
        if (d <= 4'd9) begin
            return 8'h30 | {4'h0, d};
        end else if (d == BCD_BLANK) begin
            return 8'h20;
        end else begin
            return 8'h3F;
        end
    endfunction

endpackage

// File: rtl/seg7_to_bcd.sv
// ----------------------------------------------------------------------------
// seg7_to_bcd
// Purely combinational decoder from an active-low seven-segment code to BCD.
//   i_seg      [6:0]  segment code, active-low, bit6 = a ... bit0 = g
//   o_bcd      [3:0]  0..9 for a digit, BCD_BLANK for all segments off,
//                     BCD_BAD for any other code
//   o_invalid         1 when the code is neither a digit nor blank
// ----------------------------------------------------------------------------
module seg7_to_bcd
    import seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_bcd,
    output logic       o_invalid
);

    always_comb begin
        o_bcd     = BCD_BAD;
        o_invalid = 1'b0;
        case (i_seg)
            SEG_0:     o_bcd = 4'd0;
            SEG_1:     o_bcd = 4'd1;
            SEG_2:     o_bcd = 4'd2;
            SEG_3:     o_bcd = 4'd3;
            SEG_4:     o_bcd = 4'd4;
            SEG_5:     o_bcd = 4'd5;
            SEG_6:     o_bcd = 4'd6;
            SEG_7:     o_bcd = 4'd7;
            SEG_8:     o_bcd = 4'd8;
            SEG_9:     o_bcd = 4'd9;
            SEG_BLANK: o_bcd = BCD_BLANK;
            default: begin
                o_bcd     = BCD_BAD;
                o_invalid = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/seg_display_decoder.sv
// ----------------------------------------------------------------------------
// seg_display_decoder
// Receive side of timer_60s: samples the display bundle, waits until it has
// been steady for STABLE_CYCLES samples, decodes it and emits one record per
// distinct steady value.
//
// Handshake: rec_valid rises with a complete record and the record stays
// frozen until a cycle with rec_valid && rec_ready; rec_ready is ignored
// while rec_valid is low.
//
// Parameters
//   STABLE_CYCLES  identical samples needed before a value qualifies (1..255)
//   CNT_W          stability counter width
// Ports
//   clk_50M, rst           clock, synchronous active-high reset
//   tens/out_ge/out_xiao   display digits (BCD / active-low segments)
//   point, led             decimal point mode, timer LED
//   rec_ready              consumer accepts the record
//   clr_ovr                clears the sticky overrun flag
//   rec_valid, rec_*       record outputs (digits, point, led, errors, tenths)
//   overrun                a value qualified while a record was still pending
//   rec_ascii              (only with SEG_DECODE_ASCII_EN) "T G . X" as ASCII
// Optional feature macro: SEG_DECODE_ASCII_EN
// ----------------------------------------------------------------------------
module seg_display_decoder
    import seg_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = 8
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic [3:0]  tens,
    input  logic [6:0]  out_ge,
    input  logic [6:0]  out_xiao,
    input  logic        point,
    input  logic        led,
    input  logic        rec_ready,
    input  logic        clr_ovr,
    output logic        rec_valid,
    output logic [3:0]  rec_tens,
    output logic [3:0]  rec_ge,
    output logic [3:0]  rec_xiao,
    output logic        rec_point,
    output logic        rec_led,
    output logic [2:0]  rec_err,
    output logic [13:0] rec_tenths,
    output logic        overrun
`ifdef SEG_DECODE_ASCII_EN
    ,
    output logic [31:0] rec_ascii
`endif
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

    // All-ones can never come from a legal display (tens would be 4'hF).
    localparam disp_t DISP_NONE = '1;

    rx_state_e      r_state;
    rx_state_e      w_next_state;

    disp_t          w_in;
    disp_t          r_smp;       // input register
    disp_t          r_prev;      // value whose stability r_cnt describes
    disp_t          r_last;      // last value turned into a record
    logic [CNT_W-1:0] r_cnt;

    logic [3:0]     r_tens;
    logic [3:0]     r_ge;
    logic [3:0]     r_xiao;
    logic           r_point;
    logic           r_led;
    logic [2:0]     r_err;
    logic [13:0]    r_tenths;
    logic           r_ovr;

    logic           w_same;
    logic           w_qualify;
    logic           w_load;
    logic           w_ovr_set;
    logic           w_rec_valid;

    logic [3:0]     w_ge_bcd;
    logic [3:0]     w_xiao_bcd;
    logic           w_ge_bad;
    logic           w_xiao_bad;
    logic [2:0]     w_err;
    logic           w_blank;
    logic [13:0]    w_base;
    logic [13:0]    w_tenths;

    assign w_in = {tens, out_ge, out_xiao, point, led};

    // r_cnt counts how many consecutive samples r_prev has repeated, so the
    // value that qualifies is always r_prev, never a fresh single sample.
    assign w_same      = (r_smp == r_prev);
    assign w_qualify   = (r_cnt == CNT_MAX) && (r_prev != r_last);
    assign w_rec_valid = (r_state == ST_HOLD);

    seg7_to_bcd u_dec_ge (
        .i_seg     (r_prev.ge),
        .o_bcd     (w_ge_bcd),
        .o_invalid (w_ge_bad)
    );

    seg7_to_bcd u_dec_xiao (
        .i_seg     (r_prev.xiao),
        .o_bcd     (w_xiao_bcd),
        .o_invalid (w_xiao_bad)
    );

    always_comb begin
        w_err           = 3'b000;
        w_err[ERR_TENS] = (r_prev.tens > 4'd9);
        w_err[ERR_GE]   = w_ge_bad;
        w_err[ERR_XIAO] = w_xiao_bad;
    end

    assign w_blank = (w_ge_bcd == BCD_BLANK) || (w_xiao_bcd == BCD_BLANK);

    // Wraps for undecodable digits, but those cases are forced to zero below.
    assign w_base = 14'(r_prev.tens) * 14'd100
                  + 14'(w_ge_bcd)    * 14'd10
                  + 14'(w_xiao_bcd);

    always_comb begin
        w_tenths = 14'd0;
        if (!(|w_err) && !w_blank) begin
            w_tenths = r_prev.point ? w_base : (w_base * 14'd10);
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_state <= ST_TRACK;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_ovr_set    = 1'b0;
        case (r_state)
            ST_TRACK: begin
                if (w_qualify) begin
                    w_load       = 1'b1;
                    w_next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                // The newer value is not dropped: it stays stable in r_prev
                // and qualifies again once the pending record is taken.
                if (w_qualify) begin
                    w_ovr_set = 1'b1;
                end
                if (w_rec_valid && rec_ready) begin
                    w_next_state = ST_TRACK;
                end
            end
            default: begin
                w_next_state = ST_TRACK;
            end
        endcase
    end

    // ---------------- sampling, stability, record registers ----------------
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_smp    <= DISP_NONE;
            r_prev   <= DISP_NONE;
            r_last   <= DISP_NONE;
            r_cnt    <= '0;
            r_tens   <= 4'd0;
            r_ge     <= 4'd0;
            r_xiao   <= 4'd0;
            r_point  <= 1'b0;
            r_led    <= 1'b0;
            r_err    <= 3'b000;
            r_tenths <= 14'd0;
            r_ovr    <= 1'b0;
        end else begin
            r_smp  <= w_in;
            r_prev <= r_smp;
            if (!w_same) begin
                r_cnt <= '0;
            end else if (r_cnt < CNT_MAX) begin
                r_cnt <= r_cnt + CNT_W'(1);
            end

            if (w_load) begin
                r_last   <= r_prev;
                r_tens   <= r_prev.tens;
                r_ge     <= w_ge_bcd;
                r_xiao   <= w_xiao_bcd;
                r_point  <= r_prev.point;
                r_led    <= r_prev.led;
                r_err    <= w_err;
                r_tenths <= w_tenths;
            end

            // A new overrun in the same cycle as clr_ovr wins.
            if (w_ovr_set) begin
                r_ovr <= 1'b1;
            end else if (clr_ovr) begin
                r_ovr <= 1'b0;
            end
        end
    end

`ifdef SEG_DECODE_ASCII_EN
    logic [31:0] r_ascii;
    logic [7:0]  w_tens_chr;

    assign w_tens_chr = (r_prev.tens > 4'd9) ? 8'h3F : digit_to_ascii(r_prev.tens);

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            r_ascii <= 32'h20202020;
        end else if (w_load) begin
            r_ascii <= {w_tens_chr,
                        digit_to_ascii(w_ge_bcd),
                        (r_prev.point ? 8'h2E : 8'h20),
                        digit_to_ascii(w_xiao_bcd)};
        end
    end

    assign rec_ascii = r_ascii;
`endif

    assign rec_valid  = w_rec_valid;
    assign rec_tens   = r_tens;
    assign rec_ge     = r_ge;
    assign rec_xiao   = r_xiao;
    assign rec_point  = r_point;
    assign rec_led    = r_led;
    assign rec_err    = r_err;
    assign rec_tenths = r_tenths;
    assign overrun    = r_ovr;

endmodule

// File: tb/tb_seg_display_decoder.sv
// ----------------------------------------------------------------------------
// tb_seg_display_decoder
// Directed bench for seg_display_decoder with a behavioural reference model.
// Define SEG_DECODE_ASCII_EN for both bench and RTL to cover rec_ascii.
// ----------------------------------------------------------------------------
module tb_seg_display_decoder;

    localparam int S = 4;

    // ---------------- clock / reset ----------------
    logic clk_50M = 1'b0;
    always #10 clk_50M = ~clk_50M;

    logic        rst;
    logic [3:0]  tens;
    logic [6:0]  out_ge;
    logic [6:0]  out_xiao;
    logic        point;
    logic        led;
    logic        rec_ready;
    logic        clr_ovr;
    logic        rec_valid;
    logic [3:0]  rec_tens;
    logic [3:0]  rec_ge;
    logic [3:0]  rec_xiao;
    logic        rec_point;
    logic        rec_led;
    logic [2:0]  rec_err;
    logic [13:0] rec_tenths;
    logic        overrun;
`ifdef SEG_DECODE_ASCII_EN
    logic [31:0] rec_ascii;
`endif

    seg_display_decoder #(.STABLE_CYCLES(S), .CNT_W(8)) dut (
        .clk_50M    (clk_50M),
        .rst        (rst),
        .tens       (tens),
        .out_ge     (out_ge),
        .out_xiao   (out_xiao),
        .point      (point),
        .led        (led),
        .rec_ready  (rec_ready),
        .clr_ovr    (clr_ovr),
        .rec_valid  (rec_valid),
        .rec_tens   (rec_tens),
        .rec_ge     (rec_ge),
        .rec_xiao   (rec_xiao),
        .rec_point  (rec_point),
        .rec_led    (rec_led),
        .rec_err    (rec_err),
        .rec_tenths (rec_tenths),
        .overrun    (overrun)
`ifdef SEG_DECODE_ASCII_EN
        ,
        .rec_ascii  (rec_ascii)
`endif
    );

    // Segment codes for digits 0..9, active-low abcdefg.
    logic [6:0] seg_tab [10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100};
    localparam logic [6:0] BLANK = 7'b1111111;

    // ---------------- scoreboard counters ----------------
    int n_pass  = 0;
    int n_total = 0;
    int n_rec   = 0;   // rising edges of rec_valid

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic void seg_decode(input logic [6:0] s, output logic [3:0] d,
                                       output logic bad);
        d   = 4'hF;
        bad = 1'b1;
        if (s == BLANK) begin
            d   = 4'hE;
            bad = 1'b0;
        end else begin
            for (int i = 0; i < 10; i++) begin
                if (seg_tab[i] == s) begin
                    d   = 4'(i);
                    bad = 1'b0;
                end
            end
        end
    endfunction

    function automatic logic [7:0] chr(input logic [3:0] d);
        if (d == 4'hE) return 8'h20;
        if (d > 4'd9)  return 8'h3F;
        return 8'h30 + 8'(d);
    endfunction

    logic [19:0] hist[$];     // hist[0] = most recent sampled bundle
    logic [19:0] m_last;
    bit          m_valid = 1'b0;
    logic [3:0]  m_tens, m_ge, m_xiao;
    logic        m_point, m_led, m_ovr;
    logic [2:0]  m_err;
    logic [13:0] m_tenths;
    logic [31:0] m_ascii;
    bit          started = 1'b0;

    task automatic model_load(input logic [19:0] v);
        logic [3:0] t, g, x;
        logic       gb, xb, p;
        int         val;
        t = v[19:16];
        p = v[1];
        seg_decode(v[15:9], g, gb);
        seg_decode(v[8:2],  x, xb);
        m_tens  = t;
        m_ge    = g;
        m_xiao  = x;
        m_point = p;
        m_led   = v[0];
        m_err   = {(t > 4'd9), gb, xb};
        val     = int'(t) * 100 + int'(g) * 10 + int'(x);
        if (!p) val = val * 10;
        if (m_err != 3'b000 || g == 4'hE || x == 4'hE) val = 0;
        m_tenths = 14'(val);
        m_ascii  = {((t > 4'd9) ? 8'h3F : chr(t)), chr(g), (p ? 8'h2E : 8'h20), chr(x)};
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_tens   = 4'd0;
        m_ge     = 4'd0;
        m_xiao   = 4'd0;
        m_point  = 1'b0;
        m_led    = 1'b0;
        m_err    = 3'b000;
        m_tenths = 14'd0;
        m_ovr    = 1'b0;
        m_ascii  = 32'h20202020;
        m_last   = '1;
        hist.delete();
        for (int i = 0; i <= S; i++) hist.push_back('1);
    endtask

    // A value becomes a record when the sample taken two edges ago has been
    // seen on S consecutive edges and differs from the last record.
    always @(posedge clk_50M) begin : model
        logic [19:0] v;
        bit          run;
        bit          q;
        bit          ovr_set;
        started = 1'b1;
        if (rst) begin
            model_reset();
        end else begin
            v   = hist[1];
            run = 1'b1;
            for (int i = 2; i <= S; i++) if (hist[i] != v) run = 1'b0;
            q       = run && (v != m_last);
            ovr_set = 1'b0;
            if (!m_valid) begin
                if (q) begin
                    model_load(v);
                    m_last  = v;
                    m_valid = 1'b1;
                end
            end else begin
                if (q) ovr_set = 1'b1;
                if (rec_ready) m_valid = 1'b0;
            end
            if (ovr_set) m_ovr = 1'b1;
            else if (clr_ovr) m_ovr = 1'b0;
            hist.push_front({tens, out_ge, out_xiao, point, led});
            void'(hist.pop_back());
        end
    end

    // ---------------- compare process ----------------
    logic prev_v = 1'b0;
    always @(negedge clk_50M) begin
        if (started) begin
            chk("m_valid",  rec_valid,  m_valid);
            chk("m_tens",   rec_tens,   m_tens);
            chk("m_ge",     rec_ge,     m_ge);
            chk("m_xiao",   rec_xiao,   m_xiao);
            chk("m_point",  rec_point,  m_point);
            chk("m_led",    rec_led,    m_led);
            chk("m_err",    rec_err,    m_err);
            chk("m_tenths", rec_tenths, m_tenths);
            chk("m_ovr",    overrun,    m_ovr);
`ifdef SEG_DECODE_ASCII_EN
            chk("m_ascii",  rec_ascii,  m_ascii);
`endif
            if (rec_valid === 1'b1 && prev_v == 1'b0) n_rec++;
            prev_v = (rec_valid === 1'b1);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_in(input logic [3:0] t, input logic [6:0] g, input logic [6:0] x,
                          input logic p, input logic l);
        tens     = t;
        out_ge   = g;
        out_xiao = x;
        point    = p;
        led      = l;
    endtask

    // Waits (bounded) for rec_valid; returns the number of negedges waited.
    task automatic wait_valid(input string name, output int waited);
        waited = 0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk_50M);
            waited++;
            if (rec_valid === 1'b1) break;
        end
        chk(name, rec_valid, 1'b1);
    endtask

    // ---------------- directed stimulus ----------------
    initial begin
        int w;
        rst       = 1'b1;
        rec_ready = 1'b0;
        clr_ovr   = 1'b0;
        set_in(4'd0, seg_tab[0], seg_tab[0], 1'b0, 1'b0);
        repeat (3) @(negedge clk_50M);
        chk("rst_valid",   rec_valid,  1'b0);
        chk("rst_tenths",  rec_tenths, 14'd0);
        chk("rst_overrun", overrun,    1'b0);

        // 1: first stable value after reset, consumer always ready
        set_in(4'd1, seg_tab[5], seg_tab[3], 1'b1, 1'b0);
        rec_ready = 1'b1;
        rst       = 1'b0;
        wait_valid("t1_valid", w);
        // edges counted from the first edge that samples the new inputs
        chk("t1_latency", w - 1, S + 1);
        chk("t1_tens",    rec_tens,   4'd1);
        chk("t1_ge",      rec_ge,     4'd5);
        chk("t1_xiao",    rec_xiao,   4'd3);
        chk("t1_tenths",  rec_tenths, 14'd153);
        chk("t1_err",     rec_err,    3'b000);
        repeat (15) @(negedge clk_50M);
        chk("t1_single_record", n_rec, 1);

        // 2: ge flips every 2 cycles -> never stable long enough
        for (int i = 0; i < 10; i++) begin
            set_in(4'd1, (i % 2 == 0) ? seg_tab[1] : seg_tab[2], seg_tab[3], 1'b1, 1'b0);
            repeat (2) @(negedge clk_50M);
        end
        chk("t2_no_record", n_rec, 1);
        set_in(4'd1, seg_tab[1], seg_tab[3], 1'b1, 1'b0);
        wait_valid("t2_valid", w);
        chk("t2_ge",     rec_ge,     4'd1);
        chk("t2_tenths", rec_tenths, 14'd113);

        // 3: back-pressure and overrun
        @(negedge clk_50M);
        rec_ready = 1'b0;
        set_in(4'd2, seg_tab[3], seg_tab[4], 1'b1, 1'b0);
        wait_valid("t3_valid_a", w);
        chk("t3_a_tenths", rec_tenths, 14'd234);
        set_in(4'd3, seg_tab[7], seg_tab[0], 1'b1, 1'b0);
        repeat (10) @(negedge clk_50M);
        chk("t3_hold_tenths", rec_tenths, 14'd234);
        chk("t3_hold_valid",  rec_valid,  1'b1);
        chk("t3_overrun",     overrun,    1'b1);
        rec_ready = 1'b1;
        @(negedge clk_50M);
        chk("t3_accept_gap", rec_valid, 1'b0);
        @(negedge clk_50M);
        chk("t3_b_valid",  rec_valid,  1'b1);
        chk("t3_b_tenths", rec_tenths, 14'd370);
        clr_ovr = 1'b1;
        @(negedge clk_50M);
        clr_ovr = 1'b0;
        chk("t3_ovr_clear", overrun, 1'b0);

        // 4: invalid ge segments and tens out of BCD range
        set_in(4'hA, 7'b1111110, seg_tab[0], 1'b1, 1'b0);
        wait_valid("t4_valid", w);
        chk("t4_err",    rec_err,    3'b110);
        chk("t4_ge",     rec_ge,     4'hF);
        chk("t4_tenths", rec_tenths, 14'd0);

        // 5: blank third digit in whole-second mode, then an led-only change
        set_in(4'd5, seg_tab[9], BLANK, 1'b0, 1'b0);
        wait_valid("t5_valid", w);
        chk("t5_ge",     rec_ge,     4'd9);
        chk("t5_xiao",   rec_xiao,   4'hE);
        chk("t5_tenths", rec_tenths, 14'd0);
        chk("t5_err",    rec_err,    3'b000);
        set_in(4'd5, seg_tab[9], BLANK, 1'b0, 1'b1);
        wait_valid("t5_led_valid", w);
        chk("t5_led",    rec_led, 1'b1);
        chk("t5_led_ge", rec_ge,  4'd9);

        // largest representable value
        set_in(4'd9, seg_tab[9], seg_tab[9], 1'b0, 1'b0);
        wait_valid("tmax_valid", w);
        chk("tmax_tenths", rec_tenths, 14'd9990);

        // 6: reset while a record is pending
        @(negedge clk_50M);
        rec_ready = 1'b0;
        set_in(4'd7, seg_tab[2], seg_tab[5], 1'b1, 1'b0);
        wait_valid("t6_valid", w);
        chk("t6_tenths", rec_tenths, 14'd725);
        rst = 1'b1;
        @(negedge clk_50M);
        chk("t6_rst_valid",  rec_valid,  1'b0);
        chk("t6_rst_tenths", rec_tenths, 14'd0);
        chk("t6_rst_tens",   rec_tens,   4'd0);
        rst = 1'b0;
        wait_valid("t6_reemit", w);
        chk("t6_reemit_tenths", rec_tenths, 14'd725);
        rec_ready = 1'b1;
        repeat (5) @(negedge clk_50M);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
